cga_vram_arbiter: RTL

- Time-slot arbiter for the single-port 8-bit text/graphics VRAM shared by two users:
  - the CRTC character/attribute fetch, addressed by the 6845 memory address;
  - CPU ISA memory cycles.
- Each character period (one `divclk` interval) is split into fixed slots: slots 0/1 fetch char/attr, the rest serve the CPU.
- Sits between the crtc6845 instance, the ISA memory decode, and the VRAM macro.

---
 rtl/cga_vram_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/cga_vram_arbiter.sv
// cga_vram_arbiter: time-slot arbiter sharing one 8-bit VRAM between CRTC char/attr fetch and CPU cycles.
// Optional CGA_SNOW_EN: CPU is granted in any slot, and a collision with a fetch slot corrupts that fetch (CGA snow).
module cga_vram_arbiter #(
    parameter int CHAR_CLKS = 8,
    parameter int VRAM_AW = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               divclk,
    input  logic               display_enable,
    input  logic [13:0]        mem_addr,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic               cpu_ack,
    output logic [7:0]         cpu_rdata,
    output logic               cpu_ready,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_we,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata,
    output logic [7:0]         char_out,
    output logic [7:0]         attr_out,
    output logic               fetch_valid
);
    localparam int SW = $clog2(CHAR_CLKS);
    localparam logic [SW-1:0] LAST = SW'(CHAR_CLKS - 1);
    typedef enum logic [1:0] {IDLE, PEND, ACK, DONE} state_t;
    typedef struct packed {
        logic cpu;
        logic chr;
        logic atr;
    } own_t;
    state_t state, state_n;
    own_t own, own_q, own_n;
    logic [SW-1:0] slot, slot_n;
    logic grant_n;
    logic [VRAM_AW-2:0] row;
    logic [7:0] char_q, attr_q, rdata_q;
    logic unused_bits;
    assign row = mem_addr[VRAM_AW-2:0];
    assign unused_bits = ^mem_addr[13:VRAM_AW-1];
    // Look one cycle ahead so the VRAM port and owner tag can be registered for the coming slot
    always_comb begin
        slot_n = divclk ? '0 : (slot == LAST ? slot : slot + SW'(1));
        state_n = (state == IDLE && cpu_req) ? PEND :
                  (state == PEND && own.cpu) ? ACK :
                  (state == ACK) ? DONE :
                  (state == DONE && !cpu_req) ? IDLE : state;
`ifdef CGA_SNOW_EN
        grant_n = state_n == PEND;
`else
        grant_n = state_n == PEND && slot_n >= SW'(2);
`endif
        own_n = {grant_n,
                 slot_n == '0 && (!grant_n || display_enable),
                 slot_n == SW'(1) && (!grant_n || display_enable)};
    end
    // Slot counter, CPU handshake FSM, VRAM port and the owner pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot       <= '0;
            state      <= IDLE;
            cpu_ready  <= 1'b1;
            own        <= '0;
            own_q      <= '0;
            vram_addr  <= '0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
            char_q     <= '0;
            attr_q     <= '0;
            rdata_q    <= '0;
        end else begin
            slot       <= slot_n;
            state      <= state_n;
            cpu_ready  <= (state == IDLE && cpu_req) ? 1'b0 : (state == ACK) ? 1'b1 : cpu_ready;
            own        <= own_n;
            own_q      <= own;
            vram_addr  <= grant_n ? cpu_addr : own_n.chr ? {row, 1'b0} : own_n.atr ? {row, 1'b1} : vram_addr;
            vram_we    <= grant_n && cpu_we;
            vram_wdata <= grant_n ? cpu_wdata : vram_wdata;
            char_q     <= char_out;
            attr_q     <= attr_out;
            rdata_q    <= cpu_rdata;
        end
    end
    // Read data returns one cycle after the access and is steered by the delayed owner tag
    always_comb begin
        char_out    = own_q.chr ? vram_rdata : char_q;
        attr_out    = own_q.atr ? vram_rdata : attr_q;
        cpu_rdata   = own_q.cpu ? vram_rdata : rdata_q;
        cpu_ack     = own_q.cpu;
        fetch_valid = own_q.atr;
    end
endmodule
